flag_cond_unit: RTL

- Consumer end of the ALU flag interface.
- Latches the ALU's five status flags (carry, low, overflow, zero, negative) into a processor status register (PSR).
- Evaluates 4-bit Bcond/Jcond/Scond condition codes against the PSR and returns a taken/not-taken result to the controller over a valid/ready handshake.
- Provides a 2-deep PSR save/restore stack for interrupt entry/exit.

---
 rtl/flag_cond_unit_pkg.sv | 45 ++++
 rtl/flag_cond_unit_cond_eval.sv | 47 ++++
 rtl/flag_cond_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/flag_cond_unit_pkg.sv
// Shared definitions for the flag/condition unit: PSR layout, condition codes, mask encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package flag_cond_unit_pkg;

    // PSR width and bit positions, layout {N,Z,F,L,C} at [4:0]
    localparam int NFLAGS = 5;
    localparam int PSR_C  = 0;
    localparam int PSR_L  = 1;
    localparam int PSR_F  = 2;
    localparam int PSR_Z  = 3;
    localparam int PSR_N  = 4;

    // Per-instruction-class flag write masks, {N,Z,F,L,C}
    localparam logic [NFLAGS-1:0] MASK_ARITH = 5'b10101;
    localparam logic [NFLAGS-1:0] MASK_CMP   = 5'b11010;
    localparam logic [NFLAGS-1:0] MASK_LOGIC = 5'b00000;

    // Bcond/Jcond/Scond condition codes
    typedef enum logic [3:0] {
        CC_EQ = 4'b0000,
        CC_NE = 4'b0001,
        CC_CS = 4'b0010,
        CC_CC = 4'b0011,
        CC_HI = 4'b0100,
        CC_LS = 4'b0101,
        CC_GT = 4'b0110,
        CC_LE = 4'b0111,
        CC_FS = 4'b1000,
        CC_FC = 4'b1001,
        CC_LO = 4'b1010,
        CC_HS = 4'b1011,
        CC_LT = 4'b1100,
        CC_GE = 4'b1101,
        CC_UC = 4'b1110,
        CC_NV = 4'b1111
    } cond_e;

    // Response-side state
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } resp_state_e;

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Purpose: evaluate a 4-bit condition code against a PSR value; ports: cond_i, psr_i -> taken_o.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller registers the result.
module cond_eval
    import flag_cond_unit_pkg::*;
(
    input  logic [3:0]        cond_i,
    input  logic [NFLAGS-1:0] psr_i,
    output logic              taken_o
);

    logic c_flag;
    logic l_flag;
    logic f_flag;
    logic z_flag;
    logic n_flag;

    assign c_flag = psr_i[PSR_C];
    assign l_flag = psr_i[PSR_L];
    assign f_flag = psr_i[PSR_F];
    assign z_flag = psr_i[PSR_Z];
    assign n_flag = psr_i[PSR_N];

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            CC_EQ:   taken_o = z_flag;
            CC_NE:   taken_o = ~z_flag;
            CC_CS:   taken_o = c_flag;
            CC_CC:   taken_o = ~c_flag;
            CC_HI:   taken_o = l_flag;
            CC_LS:   taken_o = ~l_flag;
            CC_GT:   taken_o = n_flag;
            CC_LE:   taken_o = ~n_flag;
            CC_FS:   taken_o = f_flag;
            CC_FC:   taken_o = ~f_flag;
            CC_LO:   taken_o = ~l_flag & ~z_flag;
            CC_HS:   taken_o = l_flag | z_flag;
            CC_LT:   taken_o = ~n_flag & ~z_flag;
            CC_GE:   taken_o = n_flag | z_flag;
            CC_UC:   taken_o = 1'b1;
            CC_NV:   taken_o = 1'b0;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Purpose: latch ALU flags into the PSR, evaluate condition codes, 2-deep PSR save/restore stack.
// Latency: response registered, resp_valid one cycle after request acceptance; 1 result/cycle sustained.
// Backpressure: resp_valid & !resp_ready holds the result and drops req_ready.
module flag_cond_unit
    import flag_cond_unit_pkg::*;
#(
    parameter int STACK_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_carry,
    input  logic              alu_low,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    input  logic              alu_negative,
    input  logic              flag_we,
    input  logic [NFLAGS-1:0] flag_mask,
    input  logic              req_valid,
    input  logic [3:0]        req_cond,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_taken,
    input  logic              resp_ready,
    input  logic              psr_save,
    input  logic              psr_restore,
    output logic [NFLAGS-1:0] psr,
    output logic              stack_err
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [NFLAGS-1:0] psr_q, psr_d;
    logic [NFLAGS-1:0] stack_q [STACK_DEPTH];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    resp_state_e       state_q, state_d;
    logic              taken_q, taken_d;

    logic [NFLAGS-1:0] alu_flags;
    logic [NFLAGS-1:0] merged;
    logic [NFLAGS-1:0] stack_top;
    logic              stack_full;
    logic              stack_empty;
    logic              do_save;
    logic              do_restore;
    logic              accept;
    logic              eval_taken;

    assign alu_flags   = {alu_negative, alu_zero, alu_overflow, alu_low, alu_carry};
    assign merged      = (psr_q & ~flag_mask) | (alu_flags & flag_mask);
    assign stack_full  = (cnt_q == CW'(STACK_DEPTH));
    assign stack_empty = (cnt_q == '0);

    // Simultaneous save+restore cancel each other; neither touches the stack.
    assign do_save    = psr_save & ~psr_restore & ~stack_full;
    assign do_restore = psr_restore & ~psr_save & ~stack_empty;

    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (CW'(i) == cnt_q - CW'(1)) begin
                stack_top = stack_q[i];
            end
        end
    end

    // psr_d doubles as the effective PSR: restore beats flag write, and both
    // the condition evaluation and a push see this post-update value.
    always_comb begin
        psr_d = psr_q;
        if (do_restore) begin
            psr_d = stack_top;
        end else if (flag_we) begin
            psr_d = merged;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (do_save) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_restore) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Error is sticky: overflowing push or underflowing pop both set it.
    assign err_d = err_q
                 | (psr_save & ~psr_restore & stack_full)
                 | (psr_restore & ~psr_save & stack_empty);

    cond_eval u_cond_eval (
        .cond_i  (req_cond),
        .psr_i   (psr_d),
        .taken_o (eval_taken)
    );

    assign resp_valid = (state_q == ST_VALID);
    assign req_ready  = ~resp_valid | resp_ready;
    assign accept     = req_valid & req_ready;
    assign resp_taken = taken_q;

    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_VALID;
                    taken_d = eval_taken;
                end
            end
            ST_VALID: begin
                if (accept) begin
                    taken_d = eval_taken;
                end else if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            psr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
            taken_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            psr_q   <= psr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            state_q <= state_d;
            taken_q <= taken_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (do_save && (CW'(i) == cnt_q)) begin
                    stack_q[i] <= psr_d;
                end
            end
        end
    end

    assign psr       = psr_q;
    assign stack_err = err_q;

endmodule
